// File: rtl/mem_write_checker.sv
// Self-checking monitor for the CPU store port: compares observed writes against a
// loaded table of expected (address, data) pairs and latches a PASS/FAIL verdict.
module mem_write_checker #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 85,
  parameter bit ORDERED = 1'b1,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              exp_valid,
  output logic              exp_ready,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              start,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] dataaddr,
  input  logic [DATA_W-1:0] writedata,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [1:0]        fail_code,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [CW-1:0]     match_count,
  output logic [31:0]       cycle_count
);

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_tbl [DEPTH];
  logic [DATA_W-1:0] data_tbl [DEPTH];
  logic [CW-1:0]     count, count_eff;
  logic [DEPTH-1:0]  matched, hit, ord_oh, uno_oh, sel_oh;
  logic              push, sel_hit;
  logic              run_load, do_match, do_mism, do_tmo;

  assign exp_ready = (state == IDLE) && (count != CW'(DEPTH));
  assign push      = (state == IDLE) && exp_valid && exp_ready;
  assign count_eff = count + CW'(push);

  assign pass = (state == PASS);
  assign fail = (state == FAIL);
  assign done = pass | fail;

  // Per-entry storage and compare; only loaded, still-unmatched entries can hit.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign hit[i] = (CW'(i) < count) && !matched[i] &&
                    (addr_tbl[i] == dataaddr) && (data_tbl[i] == writedata);
    assign ord_oh[i] = hit[i] && (match_count == CW'(i));

    always_ff @(posedge clk) begin
      if (push && count == CW'(i)) begin
        addr_tbl[i] <= exp_addr;
        data_tbl[i] <= exp_data;
      end
    end
  end

  // Lowest set bit gives the lowest-index unmatched candidate.
  assign uno_oh  = hit & (~hit + DEPTH'(1));
  assign sel_oh  = ORDERED ? ord_oh : uno_oh;
  assign sel_hit = |sel_oh;

  always_comb begin
    state_nxt = state;
    run_load  = 1'b0;
    do_match  = 1'b0;
    do_mism   = 1'b0;
    do_tmo    = 1'b0;
    case (state)
      IDLE: if (start) begin
        run_load  = 1'b1;
        state_nxt = (count_eff == '0) ? PASS : RUN;
      end
      RUN: begin
        if (memwrite && sel_hit) begin
          do_match = 1'b1;
          if (match_count + CW'(1) == count) state_nxt = PASS;
        end else if (memwrite) begin
          do_mism   = 1'b1;
          state_nxt = FAIL;
        end
        // A completing match on the last budgeted edge still wins.
        if (state_nxt == RUN && cycle_count == 32'(TIMEOUT - 1)) begin
          do_tmo    = 1'b1;
          state_nxt = FAIL;
        end
      end
      default: ;
    endcase
    if (clear) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count       <= '0;
      matched     <= '0;
      match_count <= '0;
      cycle_count <= '0;
      fail_code   <= '0;
      fail_addr   <= '0;
      fail_data   <= '0;
    end else if (clear) begin
      count       <= '0;
      matched     <= '0;
      match_count <= '0;
      cycle_count <= '0;
      fail_code   <= '0;
      fail_addr   <= '0;
      fail_data   <= '0;
    end else begin
      if (push) count <= count + CW'(1);
      if (run_load) begin
        matched     <= '0;
        match_count <= '0;
        cycle_count <= '0;
      end
      if (state == RUN) begin
        if (cycle_count != '1) cycle_count <= cycle_count + 32'd1;
        if (do_match) begin
          matched     <= matched | sel_oh;
          match_count <= match_count + CW'(1);
        end
        if (do_mism) begin
          fail_code <= 2'd1;
          fail_addr <= dataaddr;
          fail_data <= writedata;
        end
        if (do_tmo) fail_code <= 2'd2;
      end
    end
  end

endmodule
